// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state, default sizing and delay-line entry for the pe stage sequencer
package fft_pkg;
  localparam int LOG2N_DEF = 8;
  localparam int MEM_LAT_DEF = 1;
  localparam int PE_LAT_DEF = 3;
  localparam int N = 2 ** LOG2N_DEF;
  localparam int OPS = N / 4;
  localparam int DRAIN_LEN = MEM_LAT_DEF + PE_LAT_DEF;
  localparam int OP_MAXW = 10;
  localparam int STAGE_MAXW = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic valid;
    logic [OP_MAXW-1:0] op;
    logic [STAGE_MAXW-1:0] stage;
  } dl_entry_t;
endpackage

// File: rtl/pe_stage_ctrl_if.sv
// pe_stage_ctrl_if: host handshake and memory/pe bus of pe_stage_ctrl (frame_cnt only with PE_STAGE_CTRL_FRAME_CNT_EN)
interface pe_stage_ctrl_if #(
  parameter int LOG2N = 8,
  parameter int STW = $clog2(LOG2N)
);
  logic start, stall, busy, done, rd_en, bypass_n, wr_en;
  logic [LOG2N-3:0] rd_addr, wr_addr;
  logic [STW-1:0] rd_stage, wr_stage;
  logic [LOG2N-2:0] tf_addr;
`ifdef PE_STAGE_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  modport master(input start, stall,
                 output busy, done, rd_en, rd_addr, rd_stage, tf_addr, bypass_n, wr_en, wr_addr, wr_stage, frame_cnt);
  modport slave(output start, stall,
                input busy, done, rd_en, rd_addr, rd_stage, tf_addr, bypass_n, wr_en, wr_addr, wr_stage, frame_cnt);
`else
  modport master(input start, stall,
                 output busy, done, rd_en, rd_addr, rd_stage, tf_addr, bypass_n, wr_en, wr_addr, wr_stage);
  modport slave(output start, stall,
                input busy, done, rd_en, rd_addr, rd_stage, tf_addr, bypass_n, wr_en, wr_addr, wr_stage);
`endif
endinterface

// File: rtl/pe_ctrl_delay.sv
// pe_ctrl_delay: depth-D shift register of issued operations with taps at D-1 and D cycles
module pe_ctrl_delay
  import fft_pkg::*;
#(
  parameter int D = 4
) (
  input  logic      Clk,
  input  logic      Reset,
  input  dl_entry_t din,
  output dl_entry_t tap_dm1,
  output dl_entry_t tap_d
);
  dl_entry_t sr [D];
  // shift one slot per cycle; reset drops all in-flight operations
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < D; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end
  assign tap_d = sr[D-1];
  generate
    if (D == 1) begin : g_short
      assign tap_dm1 = din;
    end else begin : g_long
      assign tap_dm1 = sr[D-2];
    end
  endgenerate
endmodule

// File: rtl/pe_stage_ctrl.sv
// pe_stage_ctrl: per-stage FFT butterfly sequencer; optional frame counter via PE_STAGE_CTRL_FRAME_CNT_EN
module pe_stage_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N = 8,
  parameter int MEM_LAT = 1,
  parameter int PE_LAT = 3
) (
  input logic Clk,
  input logic Reset,
  pe_stage_ctrl_if.master bus
);
  localparam int STW = $clog2(LOG2N);
  localparam int OPW = LOG2N - 2;
  localparam int N_OPS = 2 ** OPW;
  localparam int D = MEM_LAT + PE_LAT;
  localparam int DCW = $clog2(D + 1);
  state_t state, state_nx;
  logic [OPW-1:0] op, op_nx, last_op;
  logic [STW-1:0] stage, stage_nx, last_stage;
  logic [DCW-1:0] dcnt, dcnt_nx;
  logic [LOG2N-2:0] tf, last_tf;
  logic issue, unused_bits;
  dl_entry_t din, tap_dm1, tap_d;
  assign issue = (state == RUN) && !bus.stall;
  assign tf = {1'b0, op} << stage;
  // state, counters and the last issued read fields that are held across stalls
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      op <= '0;
      stage <= '0;
      dcnt <= '0;
      last_op <= '0;
      last_stage <= '0;
      last_tf <= '0;
    end else begin
      state <= state_nx;
      op <= op_nx;
      stage <= stage_nx;
      dcnt <= dcnt_nx;
      if (issue) begin
        last_op <= op;
        last_stage <= stage;
        last_tf <= tf;
      end
    end
  end
  // next state: issue N/4 ops per stage, then drain until the stage's last write lands
  always_comb begin
    state_nx = state;
    op_nx = op;
    stage_nx = stage;
    dcnt_nx = dcnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          op_nx = '0;
          stage_nx = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          op_nx = op + OPW'(1);
          if (op == OPW'(N_OPS - 1)) begin
            state_nx = DRAIN;
            dcnt_nx = '0;
          end
        end
      end
      DRAIN: begin
        dcnt_nx = dcnt + DCW'(1);
        if (dcnt == DCW'(D - 1)) begin
          if (stage == STW'(LOG2N - 1)) state_nx = DONE;
          else begin
            state_nx = RUN;
            stage_nx = stage + STW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  assign din = {issue, OP_MAXW'(op), STAGE_MAXW'(stage)};
  pe_ctrl_delay #(.D(D)) u_delay (
    .Clk(Clk),
    .Reset(Reset),
    .din(din),
    .tap_dm1(tap_dm1),
    .tap_d(tap_d)
  );
  assign unused_bits = ^{tap_dm1.op, tap_d};
  assign bus.busy = (state == RUN) || (state == DRAIN);
  assign bus.done = state == DONE;
  assign bus.rd_en = issue;
  assign bus.rd_addr = issue ? op : last_op;
  assign bus.rd_stage = issue ? stage : last_stage;
  assign bus.tf_addr = issue ? tf : last_tf;
  assign bus.bypass_n = !(tap_dm1.valid && tap_dm1.stage == STAGE_MAXW'(LOG2N - 1));
  assign bus.wr_en = tap_d.valid;
  assign bus.wr_addr = tap_d.op[OPW-1:0];
  assign bus.wr_stage = tap_d.stage[STW-1:0];
`ifdef PE_STAGE_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  // completed frames; an aborted frame never reaches DONE so it is not counted
  always_ff @(posedge Clk) frame_cnt <= Reset ? '0 : frame_cnt + 16'(state == DONE);
  assign bus.frame_cnt = frame_cnt;
`endif
endmodule

// File: tb/tb_pe_stage_ctrl.sv
// tb_pe_stage_ctrl: scoreboard bench for pe_stage_ctrl with LOG2N=4, MEM_LAT=1, PE_LAT=3
module tb_pe_stage_ctrl;
  localparam int L = 4;
  localparam int OPS_T = 4;
  localparam int LAT = 4;
  typedef struct {int op; int stage; int tf;} op_t;
  logic Clk = 0, Reset = 1;
  pe_stage_ctrl_if #(.LOG2N(L)) bus();
  pe_stage_ctrl #(.LOG2N(L), .MEM_LAT(1), .PE_LAT(3)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  int cyc = 0, t0 = 0, checks = 0, failures = 0;
  int rd_cnt, wr_cnt, busy_cnt, done_cnt, done_rel, exp_fc = 0;
  int wr_per_stage [L];
  int rd_rel [L*OPS_T];
  int wr_rel [L*OPS_T];
  bit done_flag = 0, in_frame = 0, post_rst = 0;
  op_t rd_q[$], wr_q[$];
  int iss_cyc_q[$];
  int iss_stage[int];
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic load_expected();
    rd_q.delete();
    wr_q.delete();
    for (int s = 0; s < L; s++)
      for (int o = 0; o < OPS_T; o++) begin
        rd_q.push_back('{o, s, (o << s) % (2 ** (L - 1))});
        wr_q.push_back('{o, s, 0});
      end
    rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0; done_rel = -1; done_flag = 0;
    for (int s = 0; s < L; s++) wr_per_stage[s] = 0;
    for (int k = 0; k < L*OPS_T; k++) begin rd_rel[k] = -1; wr_rel[k] = -1; end
    in_frame = 1;
  endtask
  always @(negedge Clk) begin
    int rel, exp_byp;
    op_t e;
    if (Reset) begin
      rd_q.delete(); wr_q.delete(); iss_cyc_q.delete(); iss_stage.delete();
      post_rst = 1;
    end else begin
      rel = cyc - t0;
      if (post_rst) begin
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_bypass_n", int'(bus.bypass_n), 1);
        post_rst = 0;
      end
      if (in_frame && rel == 0) chk("idle_at_start", int'(bus.busy), 0);
      if (in_frame && rel == 1) chk("busy_after_start", int'(bus.busy), 1);
      if (bus.busy) busy_cnt++;
      if (bus.rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_addr", int'(bus.rd_addr), e.op);
          chk("rd_stage", int'(bus.rd_stage), e.stage);
          chk("tf_addr", int'(bus.tf_addr), e.tf);
          if (e.stage > 0 && e.op == 0) chk("stage_order", wr_per_stage[e.stage-1], OPS_T);
        end
        rd_cnt++;
        iss_cyc_q.push_back(cyc);
        iss_stage[cyc] = int'(bus.rd_stage);
        rd_rel[int'(bus.rd_stage)*OPS_T + int'(bus.rd_addr)] = rel;
      end
      exp_byp = (iss_stage.exists(cyc - 3) && iss_stage[cyc - 3] == L - 1) ? 0 : 1;
      chk("bypass_n", int'(bus.bypass_n), exp_byp);
      if (bus.wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", int'(bus.wr_addr), e.op);
          chk("wr_stage", int'(bus.wr_stage), e.stage);
        end
        if (iss_cyc_q.size() == 0) chk("wr_no_issue", 1, 0);
        else chk("wr_latency", cyc - iss_cyc_q.pop_front(), LAT);
        wr_cnt++;
        wr_per_stage[int'(bus.wr_stage)]++;
        wr_rel[int'(bus.wr_stage)*OPS_T + int'(bus.wr_addr)] = rel;
      end
      if (bus.done) begin
        done_cnt++;
        done_rel = rel;
        done_flag = 1;
        chk("done_rd_left", rd_q.size(), 0);
        chk("done_wr_left", wr_q.size(), 0);
        chk("done_busy", int'(bus.busy), 0);
      end
    end
  end
  // caller is #1 after a rising edge; mode 0 none, 1 fixed 3-cycle stall, 2 random stall/start
  task automatic frame(input int mode, input bit hold, input int rst_at, input int exp_done);
    int i;
    bus.start = 1;
    bus.stall = 0;
    t0 = cyc;
    load_expected();
    for (i = 1; i < 300; i++) begin
      @(posedge Clk);
      #1;
      bus.start = hold ? 1'b1 : (mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.stall = mode == 1 ? (i >= 11 && i <= 13) : mode == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
      Reset = (i == rst_at);
      if (Reset) exp_fc = 0;
      if (rst_at > 0 && i == rst_at + 1) break;
      if (done_flag) break;
    end
    in_frame = 0;
    bus.stall = 0;
    if (rst_at > 0) begin
      chk("abort_no_done", done_cnt, 0);
      return;
    end
    if (!done_flag) begin
      $display("FAIL frame_timeout: no done within 300 cycles");
      failures++;
      checks++;
      return;
    end
    chk("done_once", done_cnt, 1);
    chk("rd_count", rd_cnt, L*OPS_T);
    chk("wr_count", wr_cnt, L*OPS_T);
    if (exp_done >= 0) begin
      chk("done_cycle", done_rel, exp_done);
      chk("busy_cycles", busy_cnt, exp_done - 1);
    end
    exp_fc++;
`ifdef PE_STAGE_CTRL_FRAME_CNT_EN
    chk("frame_cnt", int'(bus.frame_cnt), exp_fc);
`endif
  endtask
  initial begin
    bus.start = 0;
    bus.stall = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    @(negedge Clk);
    chk("reset_rd_en", int'(bus.rd_en), 0);
    chk("reset_rd_addr", int'(bus.rd_addr), 0);
    chk("reset_tf_addr", int'(bus.tf_addr), 0);
    chk("reset_wr_addr", int'(bus.wr_addr), 0);
    chk("reset_done", int'(bus.done), 0);
`ifdef PE_STAGE_CTRL_FRAME_CNT_EN
    chk("reset_frame_cnt", int'(bus.frame_cnt), 0);
`endif
    @(posedge Clk);
    #1;
    frame(0, 0, -1, 33);
    frame(1, 0, -1, 36);
    chk("stall_rd_op1", rd_rel[1*OPS_T + 1], 10);
    chk("stall_rd_op2", rd_rel[1*OPS_T + 2], 14);
    chk("stall_wr_op1", wr_rel[1*OPS_T + 1], 14);
    chk("stall_wr_op2", wr_rel[1*OPS_T + 2], 18);
    frame(0, 1, -1, 33);
    frame(0, 0, -1, 33);
    frame(0, 0, 22, -1);
`ifdef PE_STAGE_CTRL_FRAME_CNT_EN
    chk("abort_frame_cnt", int'(bus.frame_cnt), 0);
`endif
    frame(0, 0, -1, 33);
    for (int k = 0; k < 3; k++) frame(2, 0, -1, -1);
    bus.start = 0;
    repeat (45) @(posedge Clk);
    #1;
    chk("final_idle", int'(bus.busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
